// File: rtl/rf_access_ctrl_pkg.sv
// Shared register-file command codes and access-controller FSM encodings.
package rf_access_ctrl_pkg;

    localparam int REG_IW = 5;

    localparam logic [1:0] RF_NOP   = 2'd0;
    localparam logic [1:0] RF_READ  = 2'd1;
    localparam logic [1:0] RF_WRITE = 2'd2;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RD_WAIT = 2'd1;
    localparam logic [1:0] ST_OP_HOLD = 2'd2;

endpackage

// File: rtl/rf_access_ctrl_wb_fifo.sv
// Write-back buffer: WB_DEPTH-entry FIFO of {rd, data}; entries are also
// presented oldest-first so the controller can search them for forwarding.
module wb_fifo
    import rf_access_ctrl_pkg::*;
#(
    parameter int LEN      = 32,
    parameter int WB_DEPTH = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              i_push,
    input  logic [REG_IW-1:0]                 i_rd,
    input  logic [LEN-1:0]                    i_data,
    input  logic                              i_pop,
    output logic [REG_IW-1:0]                 o_head_rd,
    output logic [LEN-1:0]                    o_head_data,
    output logic [WB_DEPTH-1:0][REG_IW-1:0]   o_ent_rd,
    output logic [WB_DEPTH-1:0][LEN-1:0]      o_ent_data,
    output logic [$clog2(WB_DEPTH+1)-1:0]     o_count
);
    localparam int PW = $clog2(WB_DEPTH);
    localparam int CW = $clog2(WB_DEPTH + 1);

    logic [WB_DEPTH-1:0][REG_IW-1:0] r_mem_rd;
    logic [WB_DEPTH-1:0][LEN-1:0]    r_mem_data;
    logic [PW-1:0]                   r_wr_ptr;
    logic [PW-1:0]                   r_rd_ptr;
    logic [CW-1:0]                   r_count;

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem_rd[r_wr_ptr]   <= i_rd;
            r_mem_data[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: ;
            endcase
        end
    end

    assign o_head_rd   = r_mem_rd[r_rd_ptr];
    assign o_head_data = r_mem_data[r_rd_ptr];
    assign o_count     = r_count;

    // Index 0 is the oldest live entry; only the first o_count are meaningful.
    for (genvar g = 0; g < WB_DEPTH; g++) begin : g_ent
        logic [PW-1:0] w_idx;
        assign w_idx         = r_rd_ptr + PW'(g);
        assign o_ent_rd[g]   = r_mem_rd[w_idx];
        assign o_ent_data[g] = r_mem_data[w_idx];
    end

endmodule

// File: rtl/rf_access_ctrl.sv
// Operand-read / write-back arbiter in front of a 2R/1W register file.
// Optional forwarding from the write buffer is enabled by defining RF_BYPASS_EN.
module rf_access_ctrl
    import rf_access_ctrl_pkg::*;
#(
    parameter int LEN      = 32,
    parameter int WB_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy_in,
    input  logic              rd_req_valid,
    output logic              rd_req_ready,
    input  logic [REG_IW-1:0] rs1_idx,
    input  logic [REG_IW-1:0] rs2_idx,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [LEN-1:0]    op_rs1_data,
    output logic [LEN-1:0]    op_rs2_data,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [REG_IW-1:0] wb_rd,
    input  logic [LEN-1:0]    wb_data,
    output logic [1:0]        rf_signal,
    output logic [REG_IW-1:0] rf_rs1,
    output logic [REG_IW-1:0] rf_rs2,
    output logic [REG_IW-1:0] rf_rd,
    output logic [LEN-1:0]    rf_data,
    input  logic [LEN-1:0]    rf_rs1_data,
    input  logic [LEN-1:0]    rf_rs2_data
);
    localparam int CW = $clog2(WB_DEPTH + 1);

    logic [1:0]                      r_state;
    logic [REG_IW-1:0]               r_rs1_idx, r_rs2_idx;
    logic [LEN-1:0]                  r_op1, r_op2;
    logic [REG_IW-1:0]               w_head_rd;
    logic [LEN-1:0]                  w_head_data;
    logic [WB_DEPTH-1:0][REG_IW-1:0] w_ent_rd;
    logic [WB_DEPTH-1:0][LEN-1:0]    w_ent_data;
    logic [CW-1:0]                   w_count;
    logic                            w_full, w_empty, w_push, w_pop, w_rd_go;
    logic [LEN-1:0]                  w_src1, w_src2;

`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
    logic           r_byp1_hit, r_byp2_hit;
    logic [LEN-1:0] r_byp1_data, r_byp2_data;
    logic           w_hit1, w_hit2;
    logic [LEN-1:0] w_bd1, w_bd2;

    // Later (younger) matches overwrite earlier ones.
    always_comb begin
        w_hit1 = 1'b0;
        w_hit2 = 1'b0;
        w_bd1  = '0;
        w_bd2  = '0;
        for (int i = 0; i < WB_DEPTH; i++) begin
            if (CW'(i) < w_count) begin
                if (w_ent_rd[i] == rs1_idx) begin
                    w_hit1 = 1'b1;
                    w_bd1  = w_ent_data[i];
                end
                if (w_ent_rd[i] == rs2_idx) begin
                    w_hit2 = 1'b1;
                    w_bd2  = w_ent_data[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_byp1_hit  <= 1'b0;
            r_byp2_hit  <= 1'b0;
            r_byp1_data <= '0;
            r_byp2_data <= '0;
        end else if (w_rd_go) begin
            r_byp1_hit  <= w_hit1;
            r_byp2_hit  <= w_hit2;
            r_byp1_data <= w_bd1;
            r_byp2_data <= w_bd2;
        end
    end

    assign w_src1 = r_byp1_hit ? r_byp1_data : rf_rs1_data;
    assign w_src2 = r_byp2_hit ? r_byp2_data : rf_rs2_data;
`else
    localparam bit BYP = 1'b0;
    logic w_unused_ent;
    assign w_unused_ent = ^{w_ent_rd, w_ent_data};
    assign w_src1 = rf_rs1_data;
    assign w_src2 = rf_rs2_data;
`endif

    wb_fifo #(.LEN(LEN), .WB_DEPTH(WB_DEPTH)) u_wb_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_rd        (wb_rd),
        .i_data      (wb_data),
        .i_pop       (w_pop),
        .o_head_rd   (w_head_rd),
        .o_head_data (w_head_data),
        .o_ent_rd    (w_ent_rd),
        .o_ent_data  (w_ent_data),
        .o_count     (w_count)
    );

    assign w_full  = (w_count == CW'(WB_DEPTH));
    assign w_empty = (w_count == '0);

    // Handshakes are also gated by rst so nothing is accepted while in reset.
    assign wb_ready     = rst && rdy_in && !w_full;
    assign rd_req_ready = rst && rdy_in && (r_state == ST_IDLE) && !w_full && (w_empty || BYP);
    assign w_rd_go      = rd_req_valid && rd_req_ready;
    assign w_push       = wb_valid && wb_ready && (wb_rd != '0);
    // A full buffer blocks reads, so "read wins" only ever applies when not full.
    assign w_pop        = rst && rdy_in && !w_empty && !w_rd_go;

    always_comb begin
        rf_signal = RF_NOP;
        rf_rs1    = '0;
        rf_rs2    = '0;
        rf_rd     = '0;
        rf_data   = '0;
        if (w_pop) begin
            rf_signal = RF_WRITE;
            rf_rd     = w_head_rd;
            rf_data   = w_head_data;
        end else if (w_rd_go) begin
            rf_signal = RF_READ;
            rf_rs1    = rs1_idx;
            rf_rs2    = rs2_idx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_rs1_idx <= '0;
            r_rs2_idx <= '0;
            r_op1     <= '0;
            r_op2     <= '0;
        end else if (rdy_in) begin
            case (r_state)
                ST_IDLE: if (w_rd_go) begin
                    r_state   <= ST_RD_WAIT;
                    r_rs1_idx <= rs1_idx;
                    r_rs2_idx <= rs2_idx;
                end
                ST_RD_WAIT: begin
                    r_op1   <= (r_rs1_idx == '0) ? '0 : w_src1;
                    r_op2   <= (r_rs2_idx == '0) ? '0 : w_src2;
                    r_state <= ST_OP_HOLD;
                end
                ST_OP_HOLD: if (op_ready) r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign op_valid    = (r_state == ST_OP_HOLD);
    assign op_rs1_data = r_op1;
    assign op_rs2_data = r_op2;

endmodule

// File: tb/tb_rf_access_ctrl.sv
// Scoreboard bench for rf_access_ctrl: architectural shadow model + write/operand queues.
module tb_rf_access_ctrl;
    import rf_access_ctrl_pkg::*;

    localparam int LEN   = 32;
    localparam int DEPTH = 2;
`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst, rdy_in, rd_req_valid, rd_req_ready, op_valid, op_ready;
    logic [4:0]     rs1_idx, rs2_idx, wb_rd, rf_rs1, rf_rs2, rf_rd;
    logic [LEN-1:0] op_rs1_data, op_rs2_data, wb_data, rf_data, rf_rs1_data, rf_rs2_data;
    logic           wb_valid, wb_ready;
    logic [1:0]     rf_signal;

    rf_access_ctrl #(.LEN(LEN), .WB_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .rdy_in(rdy_in),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
        .rs1_idx(rs1_idx), .rs2_idx(rs2_idx),
        .op_valid(op_valid), .op_ready(op_ready),
        .op_rs1_data(op_rs1_data), .op_rs2_data(op_rs2_data),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
        .rf_signal(rf_signal), .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_rd(rf_rd),
        .rf_data(rf_data), .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data)
    );

    always #5 clk = ~clk;

    typedef struct { logic [4:0] rd; logic [LEN-1:0] d; } wr_t;
    typedef struct { logic [LEN-1:0] a; logic [LEN-1:0] b; } rd_t;

    int errors = 0;
    int checks = 0;
    wr_t exp_wr[$];
    rd_t exp_rd[$];
    logic [LEN-1:0] tb_rf [32];
    logic [LEN-1:0] shadow [32];
    int   pend, seen;
    logic outst;
    logic [1:0] es;
    logic eov, full, rd_ok, wacc;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic timeout(input string nm);
        checks++;
        errors++;
        $display("FAIL timeout %s: no handshake within 20 cycles (t=%0t)", nm, $time);
    endtask

    // External register file: synchronous read, data valid the cycle after RF_READ.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) tb_rf[i] <= 32'h5A5A_0000 ^ (i * 32'h0101_0101);
            tb_rf[0] <= 32'hDEAD_BEEF;
        end else begin
            if (rf_signal == RF_WRITE) tb_rf[rf_rd] <= rf_data;
            if (rf_signal == RF_READ) begin
                rf_rs1_data <= tb_rf[rf_rs1];
                rf_rs2_data <= tb_rf[rf_rs2];
            end
        end
    end

    // Reference model: expected handshakes/commands, pushes expected results.
    always @(negedge clk) begin
        if (!rst) begin
            exp_wr.delete();
            exp_rd.delete();
            pend  = 0;
            outst = 1'b0;
            seen  = 0;
            for (int i = 0; i < 32; i++) shadow[i] = tb_rf[i];
        end else begin
            eov   = outst && (seen > 0);
            full  = (pend == DEPTH);
            rd_ok = rdy_in && !outst && !full && (pend == 0 || BYP);
            wacc  = wb_valid && rdy_in && (pend < DEPTH);
            es    = !rdy_in ? RF_NOP : full ? RF_WRITE :
                    (rd_req_valid && rd_ok) ? RF_READ : (pend > 0) ? RF_WRITE : RF_NOP;
            chk("op_valid", op_valid, eov);
            chk("rd_req_ready", rd_req_ready, rd_ok);
            chk("wb_ready", wb_ready, rdy_in && (pend < DEPTH));
            chk("rf_signal", rf_signal, es);
            if (es == RF_READ) begin
                chk("rf_rs1", rf_rs1, rs1_idx);
                chk("rf_rs2", rf_rs2, rs2_idx);
            end
            if (rd_req_valid && rd_ok) begin
                exp_rd.push_back('{a: (rs1_idx == 0) ? '0 : shadow[rs1_idx],
                                   b: (rs2_idx == 0) ? '0 : shadow[rs2_idx]});
                outst = 1'b1;
                seen  = 0;
            end else if (eov && op_ready && rdy_in) begin
                outst = 1'b0;
            end else if (outst && rdy_in) begin
                seen = 1;
            end
            if (es == RF_WRITE) pend--;
            if (wacc && wb_rd != 0) begin
                shadow[wb_rd] = wb_data;
                exp_wr.push_back('{rd: wb_rd, d: wb_data});
                pend++;
            end
        end
    end

    // Monitor: pops the scoreboards whenever the DUT presents a write or operands.
    always @(negedge clk) begin
        if (rst) begin
            if (rf_signal == RF_WRITE) begin
                if (exp_wr.size() == 0) begin
                    chk("unexpected_write_rd", rf_rd, 0);
                    timeout("write_queue_empty");
                end else begin
                    chk("write_rd", rf_rd, exp_wr[0].rd);
                    chk("write_data", rf_data, exp_wr[0].d);
                    void'(exp_wr.pop_front());
                end
            end
            if (op_valid) begin
                if (exp_rd.size() == 0) begin
                    timeout("operand_queue_empty");
                end else begin
                    chk("op_rs1_data", op_rs1_data, exp_rd[0].a);
                    chk("op_rs2_data", op_rs2_data, exp_rd[0].b);
                    if (op_ready && rdy_in) void'(exp_rd.pop_front());
                end
            end
        end
    end

    task automatic do_write(input logic [4:0] rd, input logic [LEN-1:0] d);
        int n = 0;
        wb_valid = 1'b1; wb_rd = rd; wb_data = d;
        @(negedge clk);
        while (!wb_ready && n < 20) begin @(negedge clk); n++; end
        if (!wb_ready) timeout("do_write");
        @(posedge clk); #1 wb_valid = 1'b0;
    endtask

    task automatic do_read(input logic [4:0] a, input logic [4:0] b);
        int n = 0;
        rd_req_valid = 1'b1; rs1_idx = a; rs2_idx = b;
        @(negedge clk);
        while (!rd_req_ready && n < 20) begin @(negedge clk); n++; end
        if (!rd_req_ready) timeout("do_read");
        @(posedge clk); #1 rd_req_valid = 1'b0;
    endtask

    task automatic wait_opv();
        int n = 0;
        @(negedge clk);
        while (!op_valid && n < 20) begin @(negedge clk); n++; end
        if (!op_valid) timeout("wait_op_valid");
        @(posedge clk); #1;
    endtask

    task automatic consume();
        wait_opv();
        op_ready = 1'b1;
        @(posedge clk); #1 op_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b0; rdy_in = 1'b1; rd_req_valid = 1'b0; op_ready = 1'b0;
        wb_valid = 1'b0; wb_rd = '0; wb_data = '0; rs1_idx = '0; rs2_idx = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_op_valid", op_valid, 0);
        chk("rst_rf_signal", rf_signal, RF_NOP);
        chk("rst_op_rs1", op_rs1_data, 0);
        chk("rst_rf_rd", rf_rd, 0);
        @(posedge clk); #1 rst = 1'b1;

        // x5 write then read x5/x0
        do_write(5'd5, 32'h1234);
        do_read(5'd5, 5'd0);
        consume();

        // four back-to-back writes
        for (int i = 0; i < 4; i++) do_write(5'(10 + i), 32'hC0DE_0000 + i);
        repeat (4) @(posedge clk);
        #1;

        // write to x0 is dropped; x0 still reads 0
        do_write(5'd0, 32'hFFFF_FFFF);
        do_read(5'd0, 5'd0);
        consume();

        // read right behind a buffered write to the same register
        do_write(5'd7, 32'hAA);
        do_read(5'd7, 5'd3);
        consume();

        // stall in OP_HOLD with op_ready asserted
        do_read(5'd5, 5'd7);
        wait_opv();
        op_ready = 1'b1; rdy_in = 1'b0;
        repeat (3) @(posedge clk);
        #1 rdy_in = 1'b1;
        @(posedge clk); #1 op_ready = 1'b0;

        // reset while a read is in RD_WAIT and the buffer holds a write
        repeat (3) @(posedge clk);
        #1 rd_req_valid = 1'b1; rs1_idx = 5'd1; rs2_idx = 5'd2;
        wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 32'h9999;
        @(negedge clk);
        chk("s6_accept", rd_req_ready, 1);
        @(posedge clk); #1 rd_req_valid = 1'b0; wb_rd = 5'd10; wb_data = 32'h1010;
        #1 chk("s6_pre_rst_signal", rf_signal, RF_WRITE);
        rst = 1'b0;
        #1;
        chk("s6_op_valid", op_valid, 0);
        chk("s6_rf_signal", rf_signal, RF_NOP);
        chk("s6_wb_ready", wb_ready, 0);
        wb_valid = 1'b0;
        @(posedge clk); #1 rst = 1'b1;

        // randomized traffic
        for (int c = 0; c < 800; c++) begin
            rdy_in       = ($urandom_range(0, 9) != 0);
            wb_valid     = $urandom_range(0, 1);
            wb_rd        = 5'($urandom_range(0, 7));
            wb_data      = $urandom;
            rd_req_valid = $urandom_range(0, 1);
            rs1_idx      = 5'($urandom_range(0, 7));
            rs2_idx      = 5'($urandom_range(0, 7));
            op_ready     = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end

        rdy_in = 1'b1; wb_valid = 1'b0; rd_req_valid = 1'b0; op_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("drain_writes_left", exp_wr.size(), 0);
        chk("drain_reads_left", exp_rd.size(), 0);
        chk("drain_op_valid", op_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
